// File: rtl/power_delay_line.sv
// rtl/power_delay_line.sv - runtime-depth, multi-lane delay line for the Hotspot2D power stream
//
// Each accepted power beat is written into a circular buffer of length depth_q and the
// beat accepted depth_q transfers earlier is emitted through a single output register.
//
// Ports:
//   aclk, axi_reset                  clock, synchronous active-high reset
//   cfg_depth, cfg_mode              requested delay / start-up mode (latched after reset and on flush)
//   flush                            one-cycle clear of pointer, fill count and pending output
//   s_axis_power_data/valid/ready    input stream (lane 0 in LSBs)
//   m_axis_power_data/valid/ready    delayed output stream
//   fill_level, primed               beats stored (saturates at depth_q), fill_level == depth_q
module power_delay_line #(
  parameter int DATA_WIDTH = 32,
  parameter int LANES      = 1,
  parameter int MAX_DEPTH  = 512,
  parameter int DEPTH_W    = $clog2(MAX_DEPTH + 1)
) (
  input  logic                        aclk,
  input  logic                        axi_reset,
  input  logic [DEPTH_W-1:0]          cfg_depth,
  input  logic                        cfg_mode,
  input  logic                        flush,
  input  logic [DATA_WIDTH*LANES-1:0] s_axis_power_data,
  input  logic                        s_axis_power_valid,
  output logic                        s_axis_power_ready,
  output logic [DATA_WIDTH*LANES-1:0] m_axis_power_data,
  output logic                        m_axis_power_valid,
  input  logic                        m_axis_power_ready,
  output logic [DEPTH_W-1:0]          fill_level,
  output logic                        primed
);

  localparam int BW = DATA_WIDTH * LANES;
  localparam int AW = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;

  logic [BW-1:0]      mem_q [MAX_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] fill_q, fill_d;
  logic [DEPTH_W-1:0] depth_q, depth_d, depth_eff, cfg_depth_clamped;
  logic               mode_q, mode_d, mode_eff;
  logic               load_q;
  logic               m_valid_q, m_valid_d;
  logic [BW-1:0]      m_data_q, m_data_d;
  logic               s_ready, acc, stream, emit, mem_we;

  assign cfg_depth_clamped = (cfg_depth > DEPTH_W'(MAX_DEPTH)) ? DEPTH_W'(MAX_DEPTH) : cfg_depth;

  // On the first cycle after reset the config is being latched at this very edge, so an
  // acceptance in that cycle must already see the new depth/mode.
  assign depth_eff = load_q ? cfg_depth_clamped : depth_q;
  assign mode_eff  = load_q ? cfg_mode : mode_q;

  assign s_ready = ~flush & (~m_valid_q | m_axis_power_ready);
  assign acc     = s_axis_power_valid & s_ready;
  assign stream  = (fill_q >= depth_eff);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    m_valid_d = m_valid_q & ~m_axis_power_ready;
    m_data_d  = m_data_q;
    mem_we    = 1'b0;
    emit      = 1'b0;
    depth_d   = (load_q | flush) ? cfg_depth_clamped : depth_q;
    mode_d    = (load_q | flush) ? cfg_mode : mode_q;

    if (flush) begin
      wr_ptr_d  = '0;
      fill_d    = '0;
      m_valid_d = 1'b0;
    end else if (acc) begin
      if (depth_eff == '0) begin
        emit     = 1'b1;
        m_data_d = s_axis_power_data;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = (DEPTH_W'(wr_ptr_q) == depth_eff - 1'b1) ? '0 : wr_ptr_q + 1'b1;
        if (!stream) begin
          fill_d = fill_q + 1'b1;
        end
        if (stream) begin
          // Slot about to be overwritten holds the beat accepted depth_eff transfers ago.
          emit     = 1'b1;
          m_data_d = mem_q[wr_ptr_q];
        end else if (!mode_eff) begin
          emit     = 1'b1;
          m_data_d = '0;
        end
      end
      if (emit) begin
        m_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (axi_reset) begin
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      load_q    <= 1'b1;
      depth_q   <= cfg_depth_clamped;
      mode_q    <= cfg_mode;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      load_q    <= 1'b0;
      depth_q   <= depth_d;
      mode_q    <= mode_d;
    end
  end

  // No reset on the storage so it can map onto a RAM; the fill counter masks stale words.
  always_ff @(posedge aclk) begin
    if (mem_we && !axi_reset) begin
      mem_q[wr_ptr_q] <= s_axis_power_data;
    end
  end

  assign s_axis_power_ready = s_ready;
  assign m_axis_power_data  = m_data_q;
  assign m_axis_power_valid = m_valid_q;
  assign fill_level         = fill_q;
  assign primed             = (fill_q == depth_q);

endmodule

// File: tb/tb_power_delay_line.sv
// tb/tb_power_delay_line.sv - self-checking bench for power_delay_line
module tb_power_delay_line;

  localparam int DW = 32;
  localparam int LN = 2;
  localparam int MD = 512;
  localparam int DWID = $clog2(MD + 1);
  localparam int BW = DW * LN;

  logic            aclk;
  logic            axi_reset;
  logic [DWID-1:0] cfg_depth;
  logic            cfg_mode;
  logic            flush;
  logic [BW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;
  logic [BW-1:0]   m_data;
  logic            m_valid;
  logic            m_ready;
  logic [DWID-1:0] fill;
  logic            primed;

  power_delay_line #(.DATA_WIDTH(DW), .LANES(LN), .MAX_DEPTH(MD)) dut (
    .aclk(aclk),
    .axi_reset(axi_reset),
    .cfg_depth(cfg_depth),
    .cfg_mode(cfg_mode),
    .flush(flush),
    .s_axis_power_data(s_data),
    .s_axis_power_valid(s_valid),
    .s_axis_power_ready(s_ready),
    .m_axis_power_data(m_data),
    .m_axis_power_valid(m_valid),
    .m_axis_power_ready(m_ready),
    .fill_level(fill),
    .primed(primed)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;

  // Reference model: delay D, mode, history of accepted beats since the last clear,
  // and the queue of emitted beats not yet taken downstream.
  int          mdl_d;
  bit          mdl_mode;
  int          mdl_k;
  logic [BW-1:0] hist[$];
  logic [BW-1:0] exp_q[$];
  bit          last_acc;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int clampd(input int c);
    return (c > MD) ? MD : c;
  endfunction

  task automatic model_clear();
    hist.delete();
    exp_q.delete();
    mdl_k    = 0;
    mdl_d    = clampd(int'(cfg_depth));
    mdl_mode = cfg_mode;
  endtask

  task automatic do_reset(input int depth, input bit mode);
    cfg_depth = DWID'(depth);
    cfg_mode  = mode;
    axi_reset = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    flush     = 1'b0;
    m_ready   = 1'b1;
    repeat (2) @(posedge aclk);
    #1 axi_reset = 1'b0;
    model_clear();
    @(negedge aclk);
    chk("rst_m_valid", {63'd0, m_valid}, '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_fill", BW'(fill), '0);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd1);
    chk("rst_primed", {63'd0, primed}, {63'd0, (mdl_d == 0)});
    @(posedge aclk);
    #1;
  endtask

  task automatic cycle(input bit sv, input logic [BW-1:0] sd, input bit mr, input bit fl);
    bit exp_valid, exp_sready, taken;
    int exp_fill;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(negedge aclk);
    exp_valid = (exp_q.size() != 0);
    chk("m_valid", {63'd0, m_valid}, {63'd0, exp_valid});
    if (exp_valid) chk("m_data", m_data, exp_q[0]);
    exp_sready = !fl && (!exp_valid || mr);
    chk("s_ready", {63'd0, s_ready}, {63'd0, exp_sready});
    exp_fill = (mdl_k < mdl_d) ? mdl_k : mdl_d;
    chk("fill_level", BW'(fill), BW'(exp_fill));
    chk("primed", {63'd0, primed}, {63'd0, (exp_fill == mdl_d)});

    taken    = exp_valid && mr;
    last_acc = sv && exp_sready;
    if (fl) begin
      model_clear();
    end else begin
      if (taken) void'(exp_q.pop_front());
      if (last_acc) begin
        hist.push_back(sd);
        if (mdl_d == 0)          exp_q.push_back(sd);
        else if (mdl_k >= mdl_d) exp_q.push_back(hist[mdl_k - mdl_d]);
        else if (!mdl_mode)      exp_q.push_back('0);
        mdl_k++;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int idx;
    int budget;
    cfg_depth = '0;
    cfg_mode  = 1'b0;
    axi_reset = 1'b1;
    flush     = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;

    // D=4 zero prefill, inputs 1..10
    do_reset(4, 1'b0);
    for (int i = 1; i <= 10; i++) cycle(1'b1, BW'(i), 1'b1, 1'b0);
    drain(3);

    // D=4 fill-then-stream
    do_reset(4, 1'b1);
    for (int i = 1; i <= 10; i++) cycle(1'b1, BW'(i), 1'b1, 1'b0);
    drain(3);

    // D=3 with random backpressure and random upstream gaps
    do_reset(3, 1'b0);
    idx = 1;
    budget = 0;
    while (idx <= 20 && budget < 500) begin
      cycle(($urandom % 4) != 0, BW'(idx), 1'($urandom % 2), 1'b0);
      if (last_acc) idx++;
      budget++;
    end
    chk("feed_done", {63'd0, (idx > 20)}, 64'd1);
    drain(3);

    // D=0 pass-through, two lanes
    do_reset(0, 1'b1);
    cycle(1'b1, {32'h0000_000B, 32'h0000_000A}, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, {$urandom, $urandom}, 1'($urandom % 2), 1'b0);
    drain(2);

    // Oversized depth clamps to MAX_DEPTH; pointer wraps several times
    do_reset(600, 1'b0);
    for (int i = 1; i <= 1100; i++) cycle(1'b1, {$urandom, 32'(i)}, 1'b1, 1'b0);
    drain(2);

    // Flush mid-stream drops the pending beat and relatches depth
    do_reset(4, 1'b0);
    for (int i = 1; i <= 5; i++) cycle(1'b1, BW'(i), 1'b1, 1'b0);
    cfg_depth = DWID'(2);
    cycle(1'b1, BW'(99), 1'b1, 1'b1);
    cfg_depth = DWID'(7);
    for (int i = 7; i <= 9; i++) cycle(1'b1, BW'(i), 1'b1, 1'b0);
    drain(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/power_delay_line.md
# power_delay_line

Parametrised, memory-backed delay line for the power stream of the Hotspot2D stencil pipeline. Each accepted power beat is written into a circular buffer, and the beat accepted D transfers earlier is read out. This keeps power aligned with the temperature window's centre cell. It adds to the fixed shift-register power buffer:

- runtime depth;
- multiple lanes;
- two start-up modes;
- flush;
- a real registered AXI-Stream handshake.

## Interface
- DATA_WIDTH, 32, bits per lane (Q1.31 power sample)
- LANES, 1, samples packed per beat (lane 0 in LSBs)
- MAX_DEPTH, 512, largest supported delay in beats (memory size)
- DEPTH_W, $clog2(MAX_DEPTH+1), width of depth/fill fields

- aclk  in  1  single clock, all logic on rising edge
- axi_reset  in  1  synchronous, active-high reset
- cfg_depth  in  DEPTH_W  requested delay D (latched, see Operation)
- cfg_mode  in  1  0 = ZERO_PREFILL, 1 = FILL_THEN_STREAM
- flush  in  1  synchronous clear of contents and pointers, one-cycle pulse
- s_axis_power_data  in  DATA_WIDTH*LANES  input beat
- s_axis_power_valid  in  1  input valid
- s_axis_power_ready  out  1  input ready
- m_axis_power_data  out  DATA_WIDTH*LANES  delayed beat
- m_axis_power_valid  out  1  output valid
- m_axis_power_ready  in  1  downstream ready
- fill_level  out  DEPTH_W  beats stored, saturates at D
- primed  out  1  fill_level == D

## Operation
- **Configuration latch.** Latched configuration depth_q/mode_q are loaded from cfg_depth/cfg_mode:
  - on the first cycle after axi_reset deasserts;
  - on every flush cycle.
  - Otherwise cfg inputs are ignored.
  - cfg_depth > MAX_DEPTH clamps to MAX_DEPTH.
- **Accept.** acc = s_valid & s_ready, with s_axis_power_ready = ~m_valid | m_ready (single output register; no combinational valid path).
- **On acc with depth_q > 0:**
  - Read mem[wr_ptr] before writing it, then write mem[wr_ptr] <= s_data in the same edge.
  - wr_ptr <= (wr_ptr == depth_q-1) ? 0 : wr_ptr+1.
  - fill_level increments, saturating at depth_q.
- **On acc with depth_q == 0:** pass-through with one register; out = s_data; fill_level stays 0; primed = 1.
- **Output selection per accepted beat:**
  - FILL state (fill_level < depth_q), ZERO_PREFILL: emit all-zero beat, m_valid <= 1.
  - FILL state, FILL_THEN_STREAM: no output beat; m_valid not set by this acceptance.
  - STREAM state (fill_level == depth_q): emit the read word; m_valid <= 1.
- **Output register:**
  - Loaded only on acc that emits.
  - m_valid clears on m_valid & m_ready when no new emitting acc occurs that cycle.
  - Data is held stable while m_valid & ~m_ready.
- **Flush:** wr_ptr <= 0, fill_level <= 0, m_valid <= 0, config relatched. Memory contents need not be cleared; the fill counter masks stale data. An input presented during a flush cycle is not accepted (s_ready forced 0).
- **Reset:** same as flush, and additionally m_data <= 0.
- **Memory:** depth MAX_DEPTH × (DATA_WIDTH*LANES). Block-RAM inference is permitted provided the externally visible timing below is unchanged.
- **Arithmetic:** no arithmetic on data; lanes are carried opaquely.

## Timing
- **Reset values:**
  - m_axis_power_valid = 0, m_axis_power_data = 0;
  - fill_level = 0; primed = (depth_q == 0);
  - s_axis_power_ready = 1 from the first post-reset cycle.
- **Latency:** an emitting acceptance at edge N drives m_valid high after edge N (visible in cycle N+1).
- **Throughput:** one beat per cycle when m_ready is held high.
- **Backpressure:**
  - With m_valid=1 and m_ready=0, s_ready=0 and no pointer or fill change.
  - A simultaneous downstream take and upstream accept in the same cycle is legal and sustains full rate.
- **Wrap:** wr_ptr wraps at depth_q-1, not at MAX_DEPTH-1.
- **Simultaneous flush and m_ready:** flush wins; the pending output beat is discarded.
- **Mid-operation:** reset or flush mid-stream loses all stored beats.
- **Ordering:** beat k out always corresponds to input beat k-D, with no reordering and no duplication.

## Test plan
- D=4, ZERO_PREFILL, LANES=1, inputs 1..10, m_ready=1 → outputs 0,0,0,0,1,2,3,4,5,6; primed rises after 4th acceptance; each output one cycle after its acceptance.
- D=4, FILL_THEN_STREAM, inputs 1..10 → exactly 6 outputs 1..6; m_valid stays 0 for the first 4 acceptances.
- D=3, inputs 1..20, m_ready toggled pseudo-randomly → sequence 0,0,0,1..17 intact; data stable while stalled; s_ready=0 whenever m_valid&~m_ready.
- D=0, LANES=2, input {0xA,0xB} → output {0xA,0xB} next cycle; fill_level=0, primed=1.
- cfg_depth=600 with MAX_DEPTH=512 → behaves as D=512, fill_level saturates at 512, first non-zero output is input beat 1 at output 513; wr_ptr wrap verified over 1100 beats.
- Stream 5 beats at D=4, pulse flush with cfg_depth=2, stream 7,8,9 → pending output dropped, outputs 0,0,7; fill_level=2.
